pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 46 ++++
 rtl/pipe_ctrl_dec.sv | 70 +++++++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and control-bundle type for the pipe_ctrl decoder and stage registers.
// The optional jump opcode is enabled by the PIPE_CTRL_JUMP_EN macro.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluctrl is kept at its canonical 3-bit encoding; the top widens it to ALUC_W.
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] aluctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t rtype_ctrl(input logic [2:0] aluc);
    ctrl_t c;
    c          = CTRL_NOP;
    c.regwrite = 1'b1;
    c.regdst   = 1'b1;
    c.aluctrl  = aluc;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_dec.sv
// Pure combinational main/ALU decoder for the decode stage.
// With PIPE_CTRL_JUMP_EN defined, opcode j is legal and reported on o_jump.
module pipe_ctrl_dec
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic [OP_W-1:0]    i_op,
  input  logic [FUNCT_W-1:0] i_funct,
  output ctrl_t              o_ctrl,
  output logic               o_beq,
  output logic               o_bne,
`ifdef PIPE_CTRL_JUMP_EN
  output logic               o_jump,
`endif
  output logic               o_illegal
);

  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_beq     = 1'b0;
    o_bne     = 1'b0;
    o_illegal = 1'b0;
`ifdef PIPE_CTRL_JUMP_EN
    o_jump    = 1'b0;
`endif
    case (i_op)
      OP_W'(OP_RTYPE): begin
        case (i_funct)
          FUNCT_W'(FN_ADD): o_ctrl = rtype_ctrl(ALU_ADD);
          FUNCT_W'(FN_SUB): o_ctrl = rtype_ctrl(ALU_SUB);
          FUNCT_W'(FN_AND): o_ctrl = rtype_ctrl(ALU_AND);
          FUNCT_W'(FN_OR):  o_ctrl = rtype_ctrl(ALU_OR);
          FUNCT_W'(FN_SLT): o_ctrl = rtype_ctrl(ALU_SLT);
          default:          o_illegal = 1'b1;
        endcase
      end
      OP_W'(OP_LW): begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.aluctrl  = ALU_ADD;
      end
      OP_W'(OP_SW): begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.aluctrl  = ALU_ADD;
      end
      OP_W'(OP_ADDI): begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.aluctrl  = ALU_ADD;
      end
      OP_W'(OP_BEQ): begin
        o_beq          = 1'b1;
        o_ctrl.aluctrl = ALU_SUB;
      end
      OP_W'(OP_BNE): begin
        o_bne          = 1'b1;
        o_ctrl.aluctrl = ALU_SUB;
      end
`ifdef PIPE_CTRL_JUMP_EN
      OP_W'(OP_J):   o_jump    = 1'b1;
`endif
      default:       o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: combinational decode plus D->E, E->M, M->W control registers.
// Defining PIPE_CTRL_JUMP_EN adds the jump_d output and makes opcode j legal.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUC_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op_d,
  input  logic [FUNCT_W-1:0] funct_d,
  input  logic               equal_d,
  input  logic               stall_d,
  input  logic               flush_e,
  output logic               branch_d,
  output logic               pcsrc_d,
  output logic               illegal_d,
`ifdef PIPE_CTRL_JUMP_EN
  output logic               jump_d,
`endif
  output logic               regdst_e,
  output logic               alusrc_e,
  output logic [ALUC_W-1:0]  aluctrl_e,
  output logic               regwrite_e,
  output logic               memtoreg_e,
  output logic               regwrite_m,
  output logic               memtoreg_m,
  output logic               memwrite_m,
  output logic               regwrite_w,
  output logic               memtoreg_w
);

  ctrl_t w_ctrl_d;
  ctrl_t w_ctrl_next_e;
  logic  w_beq;
  logic  w_bne;
  logic  w_bubble;

  ctrl_t r_ctrl_e;
  logic  r_regwrite_m;
  logic  r_memtoreg_m;
  logic  r_memwrite_m;
  logic  r_regwrite_w;
  logic  r_memtoreg_w;

  pipe_ctrl_dec #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_dec (
    .i_op      (op_d),
    .i_funct   (funct_d),
    .o_ctrl    (w_ctrl_d),
    .o_beq     (w_beq),
    .o_bne     (w_bne),
`ifdef PIPE_CTRL_JUMP_EN
    .o_jump    (jump_d),
`endif
    .o_illegal (illegal_d)
  );

  // Branch resolution is ungated; the hazard unit decides whether to honour it.
  assign branch_d = w_beq | w_bne;
  assign pcsrc_d  = (w_beq & equal_d) | (w_bne & ~equal_d);

  assign w_bubble      = stall_d | flush_e;
  assign w_ctrl_next_e = w_bubble ? CTRL_NOP : w_ctrl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_e <= CTRL_NOP;
    end else begin
      r_ctrl_e <= w_ctrl_next_e;
    end
  end

  // Later stages never stall: the hazard unit only bubbles the D->E boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
    end else begin
      r_regwrite_m <= r_ctrl_e.regwrite;
      r_memtoreg_m <= r_ctrl_e.memtoreg;
      r_memwrite_m <= r_ctrl_e.memwrite;
      r_regwrite_w <= r_regwrite_m;
      r_memtoreg_w <= r_memtoreg_m;
    end
  end

  assign regdst_e   = r_ctrl_e.regdst;
  assign alusrc_e   = r_ctrl_e.alusrc;
  assign aluctrl_e  = ALUC_W'(r_ctrl_e.aluctrl);
  assign regwrite_e = r_ctrl_e.regwrite;
  assign memtoreg_e = r_ctrl_e.memtoreg;
  assign regwrite_m = r_regwrite_m;
  assign memtoreg_m = r_memtoreg_m;
  assign memwrite_m = r_memwrite_m;
  assign regwrite_w = r_regwrite_w;
  assign memtoreg_w = r_memtoreg_w;

endmodule
